// File: rtl/vector_load_packer.sv
// vector_load_packer: packs streamed vector elements into one word and issues a single register-file write.
module vector_load_packer #(
  parameter int DATA_LEN = 32,
  parameter int SCALAR_REG_LEN = 64,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic                            start,
  input  logic [4:0]                      rd_in,
  input  logic                            vm_in,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] mask_in,
  input  logic [DATA_LEN-1:0]             length_in,
  input  logic [2:0]                      data_type_in,
  input  logic                            elem_valid,
  input  logic [SCALAR_REG_LEN-1:0]       elem_data,
  output logic                            elem_ready,
  input  logic [1:0]                      rf_status,
  output logic [1:0]                      rf_signal,
  output logic [4:0]                      rd,
  output logic                            vm,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] mask,
  output logic [DATA_LEN-1:0]             length,
  output logic [2:0]                      data_type,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] data,
  output logic                            write_back_enabled,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int VL = VECTOR_SIZE * DATA_LEN;
  localparam int KW = $clog2(VL / 8 + 1);
  localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
  localparam logic [1:0] RF_FINISHED = 2'b10;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, WAIT_ACK} state_t;
  state_t state_q;
  logic [KW-1:0] k_q;
  logic [4:0] rd_q;
  logic vm_q, done_q, err_q;
  logic [VL-1:0] mask_q, data_q, data_d;
  logic [DATA_LEN-1:0] length_q, max_in, len_clip;
  logic [2:0] data_type_q;
  logic [SCALAR_REG_LEN-1:0] lane;
  // Legal element types encode log2(bytes) in bits [1:0]; bit 2 set is unsupported.
  always_comb begin
    max_in = DATA_LEN'(VL >> (3 + data_type_in[1:0]));
    len_clip = length_in > max_in ? max_in : length_in;
    lane = elem_data & ~({SCALAR_REG_LEN{1'b1}} << (8 << data_type_q[1:0]));
    data_d = data_q | (VL'(lane) << (32'(k_q) << (3 + data_type_q[1:0])));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q <= '0;
      rd_q <= '0;
      vm_q <= 1'b0;
      mask_q <= '0;
      length_q <= '0;
      data_type_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else if (rdy_in) begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (data_type_in[2]) err_q <= 1'b1;
          else begin
            rd_q <= rd_in;
            vm_q <= vm_in;
            mask_q <= mask_in;
            data_type_q <= data_type_in;
            length_q <= len_clip;
            data_q <= '0;
            k_q <= '0;
            err_q <= length_in > max_in;
            state_q <= len_clip == '0 ? WRITE : COLLECT;
          end
        end
        COLLECT: if (elem_valid) begin
          data_q <= data_d;
          k_q <= k_q + KW'(1);
          if (DATA_LEN'(k_q) + DATA_LEN'(1) == length_q) state_q <= WRITE;
        end
        WRITE: state_q <= WAIT_ACK;
        WAIT_ACK: if (rf_status == RF_FINISHED) begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign elem_ready = rdy_in && state_q == COLLECT;
  assign write_back_enabled = state_q == WRITE;
  assign rf_signal = state_q == WRITE ? VECTOR_RF_WRITE : 2'b00;
  assign busy = state_q != IDLE;
  assign rd = rd_q;
  assign vm = vm_q;
  assign mask = mask_q;
  assign length = length_q;
  assign data_type = data_type_q;
  assign data = data_q;
  assign done = done_q;
  assign err = err_q;
endmodule
